// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner encodings and defaults.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DBG  = 2'b10
  } owner_t;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  // Wide enough for the largest allowed MAX_CPU_RUN (15).
  localparam int RUN_W = 4;

endpackage

// File: rtl/arb_prio_starve.sv
// Two-way winner select: cpu has priority, but dbg is guaranteed a slot after
// MAX_CPU_RUN consecutive cpu grants taken while dbg was waiting.
module arb_prio_starve
  import dmem_arb_pkg::*;
#(
  parameter int MAX_CPU_RUN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic dbg_req,
  output logic cpu_win,
  output logic dbg_win
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CPU_RUN);

  logic [RUN_W-1:0] run_cnt;
  logic             starved;

  // Winner of this cycle; both wins are held low while reset is asserted.
  always_comb begin
    starved = (run_cnt == RUN_MAX);
    dbg_win = reset & dbg_req & (~cpu_req | starved);
    cpu_win = reset & cpu_req & ~dbg_win;
  end

  // Count cpu grants taken over a waiting dbg; any dbg grant or idle dbg clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt <= '0;
    end else if (dbg_win || !dbg_req) begin
      run_cnt <= '0;
    end else if (cpu_win && (run_cnt != RUN_MAX)) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the mips core (cpu) and a debug master
// (dbg). One access per cycle; read data comes back registered one cycle later.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  logic          cpu_win;
  logic          dbg_win;
  owner_t        own_q;
  logic          cpu_rvld_p1;
  logic          dbg_rvld_p1;
  logic [DW-1:0] cpu_rdata_p1;
  logic [DW-1:0] dbg_rdata_p1;

  arb_prio_starve #(
    .MAX_CPU_RUN(MAX_CPU_RUN)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .cpu_win (cpu_win),
    .dbg_win (dbg_win)
  );

  assign cpu_gnt = cpu_win;
  assign dbg_gnt = dbg_win;

  // Route the winner onto the memory port; an idle port drives all zeros.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_win) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Owner state: remembers who used the port last cycle, IDLE when nobody did.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_q <= OWN_NONE;
    end else if (cpu_win) begin
      own_q <= OWN_CPU;
    end else if (dbg_win) begin
      own_q <= OWN_DBG;
    end else begin
      own_q <= OWN_NONE;
    end
  end

  assign owner = own_q;

  // Stage p0 -> p1: capture read data of a granted read; rdata holds until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rvld_p1  <= 1'b0;
      dbg_rvld_p1  <= 1'b0;
      cpu_rdata_p1 <= '0;
      dbg_rdata_p1 <= '0;
    end else begin
      cpu_rvld_p1 <= cpu_win & ~cpu_we;
      dbg_rvld_p1 <= dbg_win & ~dbg_we;
      if (cpu_win && !cpu_we) begin
        cpu_rdata_p1 <= mem_rdata;
      end
      if (dbg_win && !dbg_we) begin
        dbg_rdata_p1 <= mem_rdata;
      end
    end
  end

  assign cpu_rvalid = cpu_rvld_p1;
  assign dbg_rvalid = dbg_rvld_p1;
  assign cpu_rdata  = cpu_rdata_p1;
  assign dbg_rdata  = dbg_rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a small dmem model, a vector table, directed corner
// sequences and a randomized run against a behavioural arbitration model.
module tb_dmem_arbiter;

  localparam int MAXR = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;

  logic [31:0] mem [0:255] = '{default: '0};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_CPU_RUN(MAXR)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  // dmem: combinational read, write on the clock edge
  assign mem_rdata = mem[8'(mem_addr >> 2)];
  always @(posedge clk) if (mem_we) mem[8'(mem_addr >> 2)] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       cr, cw, dr, dw;
    logic       eg_c, eg_d, e_we;
    logic [1:0] e_own;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string       pat;
    logic [31:0] ca, da, cd, dd, ea, ed;
    logic        cr, cw, dr, dw, ec, ed_g;
    logic        c_hold, d_hold, crv, drv_e, ck_known, dk_known;
    logic [31:0] crd, drd;
    logic [31:0] ref_mem [0:15];
    int          dwait, ci, di;

    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 2'b00};
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1, 2'b01};
    tbl[2]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0, 2'b10};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0, 2'b01};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0, 2'b01};
    tbl[5]  = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1, 2'b01};
    tbl[6]  = '{1'b1,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0, 2'b01};
    tbl[7]  = '{1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b1, 2'b10};
    tbl[8]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1, 2'b01};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 2'b01};
    tbl[10] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0, 2'b01};
    tbl[11] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0, 2'b01};
    tbl[12] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0, 2'b01};
    tbl[13] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0, 2'b01};
    tbl[14] = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0, 2'b10};

    // ---- reset holds everything quiet, first cycle after release grants cpu
    reset = 1'b0;
    drv(1'b1, 1'b1, 32'h80, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
    check("rst_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    check("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    check("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    check("rst_owner", {30'b0, owner}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
    check("rel_mem_we", {31'b0, mem_we}, 32'd1);
    tick();
    check("rel_owner", {30'b0, owner}, 32'd1);

    // ---- cpu read of 0x54 (seeded with 7 by a cpu write first)
    drv(1'b1, 1'b1, 32'h54, 32'h7, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("seed_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
    tick();
    drv(1'b1, 1'b0, 32'h54, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rd_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
    check("rd_mem_addr", mem_addr, 32'h54);
    check("rd_mem_we", {31'b0, mem_we}, 32'd0);
    tick();
    check("rd_rvalid_c1", {31'b0, cpu_rvalid}, 32'd1);
    check("rd_rdata_c1", cpu_rdata, 32'h7);
    drv(1'b0, 1'b1, 32'h99, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("idle_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
    check("idle_mem_addr", mem_addr, 32'h0);
    check("idle_mem_we", {31'b0, mem_we}, 32'd0);
    tick();
    check("rd_rvalid_c2", {31'b0, cpu_rvalid}, 32'd0);
    check("rd_rdata_hold", cpu_rdata, 32'h7);

    // ---- dbg write alone
    drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    check("dw_mem_we", {31'b0, mem_we}, 32'd1);
    check("dw_mem_addr", mem_addr, 32'h10);
    check("dw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("dw_dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
    check("dw_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
    tick();
    check("dw_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    check("dw_owner", {30'b0, owner}, 32'd2);
    check("dw_mem_content", mem[4], 32'hDEAD_BEEF);

    // ---- vector table
    for (int i = 0; i < 15; i++) begin
      ca = 32'h40 + 32'(i) * 8;
      da = 32'h44 + 32'(i) * 8;
      cd = 32'hC000_0000 + 32'(i);
      dd = 32'hD000_0000 + 32'(i);
      drv(tbl[i].cr, tbl[i].cw, ca, cd, tbl[i].dr, tbl[i].dw, da, dd);
      ea = tbl[i].eg_c ? ca : (tbl[i].eg_d ? da : 32'h0);
      ed = tbl[i].eg_c ? cd : (tbl[i].eg_d ? dd : 32'h0);
      @(negedge clk);
      check($sformatf("tbl%0d_cpu_gnt", i), {31'b0, cpu_gnt}, {31'b0, tbl[i].eg_c});
      check($sformatf("tbl%0d_dbg_gnt", i), {31'b0, dbg_gnt}, {31'b0, tbl[i].eg_d});
      check($sformatf("tbl%0d_mem_we", i), {31'b0, mem_we}, {31'b0, tbl[i].e_we});
      check($sformatf("tbl%0d_mem_addr", i), mem_addr, ea);
      check($sformatf("tbl%0d_mem_wdata", i), mem_wdata, ed);
      tick();
      check($sformatf("tbl%0d_owner", i), {30'b0, owner}, {30'b0, tbl[i].e_own});
      check($sformatf("tbl%0d_cpu_rvalid", i), {31'b0, cpu_rvalid}, {31'b0, tbl[i].eg_c & ~tbl[i].cw});
      check($sformatf("tbl%0d_dbg_rvalid", i), {31'b0, dbg_rvalid}, {31'b0, tbl[i].eg_d & ~tbl[i].dw});
    end

    // ---- starvation bound: both requests held for 12 cycles
    drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    pat = "CCCCDCCCCDCC";
    drv(1'b1, 1'b0, 32'h60, 32'h0, 1'b1, 1'b0, 32'h64, 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("starve%0d_cpu_gnt", i), {31'b0, cpu_gnt}, {31'b0, pat[i] == "C"});
      check($sformatf("starve%0d_dbg_gnt", i), {31'b0, dbg_gnt}, {31'b0, pat[i] == "D"});
      tick();
      check($sformatf("starve%0d_owner", i), {30'b0, owner}, (pat[i] == "C") ? 32'd1 : 32'd2);
    end

    // ---- collision: both write 0x20, cpu first then dbg
    drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drv(1'b1, 1'b1, 32'h20, 32'h1, 1'b1, 1'b1, 32'h20, 32'h2);
    @(negedge clk);
    check("col0_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
    check("col0_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    check("col0_mem_wdata", mem_wdata, 32'h1);
    tick();
    drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h2);
    @(negedge clk);
    check("col1_dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
    check("col1_mem_wdata", mem_wdata, 32'h2);
    check("col1_mem_we", {31'b0, mem_we}, 32'd1);
    tick();
    check("col_final_mem", mem[8], 32'h2);

    // ---- reset in the middle of a cpu read, with contention history before it
    drv(1'b1, 1'b0, 32'h54, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    tick();
    @(negedge clk);
    check("rmr_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
    reset = 1'b0;
    #1;
    check("rmr_gnt_in_rst", {31'b0, cpu_gnt}, 32'd0);
    tick();
    check("rmr_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    check("rmr_cpu_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    pat = "CCCCD";
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rmr%0d_cpu_gnt", i), {31'b0, cpu_gnt}, {31'b0, pat[i] == "C"});
      check($sformatf("rmr%0d_dbg_gnt", i), {31'b0, dbg_gnt}, {31'b0, pat[i] == "D"});
      @(negedge clk);
      #1;
    end
    drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // ---- randomized traffic against the behavioural model
    for (int k = 0; k < 16; k++) ref_mem[k] = 32'h0;
    dwait = 0;  // cpu grants dbg has sat through while waiting
    c_hold = 1'b0; d_hold = 1'b0;
    ck_known = 1'b0; dk_known = 1'b0;
    crd = 32'h0; drd = 32'h0;
    cr = 1'b0; cw = 1'b0; dr = 1'b0; dw = 1'b0;
    ci = 0; di = 0; ca = 32'h0; da = 32'h0; cd = 32'h0; dd = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if (!c_hold) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = 1'($urandom_range(0, 1));
        ci = int'($urandom_range(0, 15));
        ca = 32'h200 + 32'(ci) * 4;
        cd = $urandom;
      end
      if (!d_hold) begin
        dr = ($urandom_range(0, 1) != 0);
        dw = 1'($urandom_range(0, 1));
        di = int'($urandom_range(0, 15));
        da = 32'h200 + 32'(di) * 4;
        dd = $urandom;
      end
      drv(cr, cw, ca, cd, dr, dw, da, dd);
      ec   = cr && !(dr && dwait >= MAXR);
      ed_g = dr && !ec;
      @(negedge clk);
      check("rnd_cpu_gnt", {31'b0, cpu_gnt}, {31'b0, ec});
      check("rnd_dbg_gnt", {31'b0, dbg_gnt}, {31'b0, ed_g});
      check("rnd_mem_we", {31'b0, mem_we}, {31'b0, (ec & cw) | (ed_g & dw)});
      check("rnd_mem_addr", mem_addr, ec ? ca : (ed_g ? da : 32'h0));
      check("rnd_mem_wdata", mem_wdata, ec ? cd : (ed_g ? dd : 32'h0));
      tick();
      crv = ec && !cw;
      drv_e = ed_g && !dw;
      if (crv) begin crd = ref_mem[ci]; ck_known = 1'b1; end
      if (drv_e) begin drd = ref_mem[di]; dk_known = 1'b1; end
      if (ec && cw) ref_mem[ci] = cd;
      if (ed_g && dw) ref_mem[di] = dd;
      dwait = (ec && dr) ? dwait + 1 : 0;
      c_hold = cr && !ec;
      d_hold = dr && !ed_g;
      check("rnd_cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, crv});
      check("rnd_dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, drv_e});
      check("rnd_owner", {30'b0, owner}, ec ? 32'd1 : (ed_g ? 32'd2 : 32'd0));
      if (ck_known) check("rnd_cpu_rdata", cpu_rdata, crd);
      if (dk_known) check("rnd_dbg_rdata", dbg_rdata, drd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
